// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared FSM encodings and requester count for the SRAM arbiter
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int NUM_REQ = 2;

endpackage

// File: rtl/sram_arb_rr.sv
// rtl/sram_arb_rr.sv - two-way winner select; round-robin unless SRAM_ARB_FIXED_PRI_EN
// (fixed priority to requester 0 when SRAM_ARB_FIXED_PRI_EN is defined)
module sram_arb_rr
  import sram_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               grant_en_i,
  output logic               winner_o
);

`ifdef SRAM_ARB_FIXED_PRI_EN
  assign winner_o = ~req_i[0];
`else
  logic last_q, last_d;

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    if (req_i == 2'b11) winner_o = ~last_q;
    else                winner_o = ~req_i[0];
    last_d = grant_en_i ? winner_o : last_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= 1'b1;
    else         last_q <= last_d;
  end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-requester SRAM access arbiter with per-op wait states
// Arbitration mode selected by SRAM_ARB_FIXED_PRI_EN (see sram_arb_rr).
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int addr_width = 4,
  parameter int word_width = 8,
  parameter int write_wait = 1,
  parameter int read_wait  = 2
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [addr_width-1:0] addr0,
  input  logic [addr_width-1:0] addr1,
  input  logic [word_width-1:0] wdata0,
  input  logic [word_width-1:0] wdata1,
  output logic [1:0]            gnt,
  output logic [1:0]            done,
  output logic [word_width-1:0] rdata,
  output logic [addr_width-1:0] sram_addr,
  output logic [word_width-1:0] sram_din,
  output logic                  sram_we,
  input  logic [word_width-1:0] sram_dout
);

  localparam logic [3:0] WR_LOAD = 4'(write_wait - 1);
  localparam logic [3:0] RD_LOAD = 4'(read_wait - 1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [1:0]            gnt_q, gnt_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [word_width-1:0] din_q, din_d;
  logic                  we_q, we_d;
  logic [word_width-1:0] rdata_q, rdata_d;
  logic                  winner;
  logic                  grant_en;
  logic                  sel_we;

  assign grant_en = (state_q == IDLE) && (|req);
  assign sel_we   = winner ? we[1] : we[0];

  sram_arb_rr u_arb (
    .clk_i      (hclk),
    .rst_ni     (hresetn),
    .req_i      (req),
    .grant_en_i (grant_en),
    .winner_o   (winner)
  );

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = ACCESS;
      ACCESS:  if (cnt_q == 4'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    done = (state_q == DONE) ? gnt_q : 2'b00;
  end

  always_comb begin
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    din_d   = din_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (grant_en) begin
        gnt_d  = winner ? 2'b10 : 2'b01;
        addr_d = winner ? addr1 : addr0;
        din_d  = winner ? wdata1 : wdata0;
        we_d   = sel_we;
        cnt_d  = sel_we ? WR_LOAD : RD_LOAD;
      end
      // we_q still tells read from write on the final ACCESS edge.
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          we_d = 1'b0;
          if (!we_q) rdata_d = sram_dout;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    gnt_d = 2'b00;
      default: ;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      cnt_q   <= '0;
      gnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  assign gnt       = gnt_q;
  assign sram_addr = addr_q;
  assign sram_din  = din_q;
  assign sram_we   = we_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed vector bench for sram_arbiter (either SRAM_ARB_FIXED_PRI_EN build)
module tb_sram_arbiter;

  logic       hclk = 1'b0;
  logic       hresetn;
  logic [1:0] req, we;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic [1:0] gnt, done;
  logic [7:0] rdata;
  logic [3:0] sram_addr;
  logic [7:0] sram_din;
  logic       sram_we;
  logic [7:0] sram_dout;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  always #5 hclk = ~hclk;
  always @(posedge hclk) cyc <= cyc + 1;

  sram_arbiter #(.addr_width(4), .word_width(8), .write_wait(1), .read_wait(2)) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .req       (req),
    .we        (we),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_we   (sram_we),
    .sram_dout (sram_dout)
  );

  typedef struct {
    logic [1:0] req;
    logic [1:0] we;
    logic [3:0] a0;
    logic [3:0] a1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] dout;
    logic [1:0] gnt_rr;
    logic [1:0] gnt_fx;
    int         lat;
    logic [7:0] rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " gnt"}, 32'(gnt), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " sram_we"}, 32'(sram_we), 0);
    chk({tag, " rdata"}, 32'(rdata), 0);
    chk({tag, " sram_addr"}, 32'(sram_addr), 0);
    chk({tag, " sram_din"}, 32'(sram_din), 0);
  endtask

  task automatic wait_done(output int k);
    k = 1;
    while (done == 2'b00 && k < 20) begin
      @(negedge hclk);
      k++;
    end
  endtask

  initial begin
    logic [1:0] eg;
    logic [1:0] exp_order[4];
    logic [1:0] g;
    logic [3:0] ea;
    logic [7:0] ed;
    int         k, t_prev, saw_done;

    vecs[0] = '{2'b01, 2'b01, 4'h3, 4'h0, 8'hA5, 8'h00, 8'h00, 2'b01, 2'b01, 2, 8'h00};
    vecs[1] = '{2'b10, 2'b00, 4'h0, 4'h3, 8'h00, 8'h00, 8'hA5, 2'b10, 2'b10, 3, 8'hA5};
    vecs[2] = '{2'b10, 2'b10, 4'h0, 4'h7, 8'h00, 8'h3C, 8'hEE, 2'b10, 2'b10, 2, 8'hA5};
    vecs[3] = '{2'b01, 2'b00, 4'h9, 4'h0, 8'h00, 8'h00, 8'h5A, 2'b01, 2'b01, 3, 8'h5A};
    vecs[4] = '{2'b11, 2'b00, 4'h1, 4'h2, 8'h11, 8'h22, 8'hC3, 2'b10, 2'b01, 3, 8'hC3};

    hresetn = 1'b0;
    req = 0; we = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; sram_dout = 0;
    repeat (2) @(negedge hclk);
    chk_all_zero("reset");
    hresetn = 1'b1;
    @(negedge hclk);
    chk("idle gnt", 32'(gnt), 0);

    for (int i = 0; i < 5; i++) begin
      @(negedge hclk);
      req = vecs[i].req; we = vecs[i].we;
      addr0 = vecs[i].a0; addr1 = vecs[i].a1;
      wdata0 = vecs[i].d0; wdata1 = vecs[i].d1; sram_dout = vecs[i].dout;
`ifdef SRAM_ARB_FIXED_PRI_EN
      eg = vecs[i].gnt_fx;
`else
      eg = vecs[i].gnt_rr;
`endif
      ea = eg[1] ? vecs[i].a1 : vecs[i].a0;
      ed = eg[1] ? vecs[i].d1 : vecs[i].d0;
      @(negedge hclk);
      chk($sformatf("v%0d gnt", i), 32'(gnt), 32'(eg));
      chk($sformatf("v%0d sram_addr", i), 32'(sram_addr), 32'(ea));
      chk($sformatf("v%0d sram_din", i), 32'(sram_din), 32'(ed));
      chk($sformatf("v%0d sram_we", i), 32'(sram_we), 32'(|(vecs[i].we & eg)));
      req = 2'b00;
      wait_done(k);
      chk($sformatf("v%0d done", i), 32'(done), 32'(eg));
      chk($sformatf("v%0d latency", i), 32'(k), 32'(vecs[i].lat));
      chk($sformatf("v%0d rdata", i), 32'(rdata), 32'(vecs[i].rdata));
      chk($sformatf("v%0d sram_we at done", i), 32'(sram_we), 0);
      @(negedge hclk);
      chk($sformatf("v%0d done pulse", i), 32'(done), 0);
      chk($sformatf("v%0d gnt released", i), 32'(gnt), 0);
      chk($sformatf("v%0d addr held", i), 32'(sram_addr), 32'(ea));
    end

    // Tie held over four back-to-back writes.
`ifdef SRAM_ARB_FIXED_PRI_EN
    exp_order = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    @(negedge hclk);
    req = 2'b11; we = 2'b11; addr0 = 4'h4; addr1 = 4'h5; wdata0 = 8'h40; wdata1 = 8'h50;
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      k = 0;
      while (gnt == 2'b00 && k < 20) begin
        @(negedge hclk);
        k++;
      end
      g = gnt;
      chk($sformatf("tie grant %0d", i), 32'(g), 32'(exp_order[i]));
      if (i > 0) chk($sformatf("tie spacing %0d", i), 32'(cyc - t_prev), 3);
      t_prev = cyc;
      if (i == 3) req = 2'b00;
      k = 0;
      while (gnt != 2'b00 && k < 20) begin
        @(negedge hclk);
        k++;
      end
    end

    // Requester 0 withdraws mid-read; the access must still complete.
    @(negedge hclk);
    req = 2'b01; we = 2'b00; addr0 = 4'h6; sram_dout = 8'h77;
    @(negedge hclk);
    chk("drop gnt", 32'(gnt), 32'b01);
    req = 2'b00;
    @(negedge hclk);
    chk("drop still granted", 32'(gnt), 32'b01);
    chk("drop not yet done", 32'(done), 0);
    @(negedge hclk);
    chk("drop done", 32'(done), 32'b01);
    chk("drop rdata", 32'(rdata), 32'h77);
    @(negedge hclk);

    // Reset in the middle of a read.
    @(negedge hclk);
    req = 2'b10; we = 2'b00; addr1 = 4'h8; sram_dout = 8'h99;
    @(negedge hclk);
    chk("rst pre gnt", 32'(gnt), 32'b10);
    req = 2'b00;
    #2 hresetn = 1'b0;
    #1 chk_all_zero("async reset");
    @(negedge hclk);
    hresetn = 1'b1;
    saw_done = 0;
    repeat (4) begin
      @(negedge hclk);
      if (done != 2'b00) saw_done++;
    end
    chk("no done after reset", 32'(saw_done), 0);
    req = 2'b11; we = 2'b01; addr0 = 4'h2; wdata0 = 8'hAB; addr1 = 4'hF; wdata1 = 8'hCD;
    @(negedge hclk);
    chk("post-reset gnt", 32'(gnt), 32'b01);
    chk("post-reset din", 32'(sram_din), 32'hAB);
    chk("post-reset we", 32'(sram_we), 1);
    req = 2'b00;
    @(negedge hclk);
    chk("post-reset done", 32'(done), 32'b01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
